// File: rtl/spi_sram_target.sv
// SPI SRAM responder: 23LC-style READ (0x03) / WRITE (0x02) on an internal 2**ADDR_W byte array.
// Optional mode register (RDSR 0x05 / WRSR 0x01) is enabled by defining SPI_TARGET_MODE_REG_EN.
module spi_sram_target #(
  parameter int ADDR_W  = 10,
  parameter bit OUT_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              busy,
  input  logic              bd_en,
  input  logic              bd_wr,
  input  logic [ADDR_W-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic [7:0]        bd_rdata
);
  // Handshake: no valid/ready; a transaction is framed by cs_n low, one mosi/miso bit per clk,
  // and any cs_n-high edge returns the responder to IDLE.
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, RDSR, WRSR, IGNORE} state_t;

  state_t            state;
  logic [4:0]        bit_cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        shift;
  logic              is_read;
  logic              miso_q;
  logic [7:0]        mem [2**ADDR_W];
  logic [1:0]        mode_sel;
  logic [ADDR_W-1:0] addr_first;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_byte;
  logic [7:0]        wbyte;
  logic              spi_we;

`ifdef SPI_TARGET_MODE_REG_EN
  logic [7:0] mode;
  assign mode_sel = mode[7:6];
`else
  assign mode_sel = 2'b01;
`endif

  assign busy       = (state != IDLE);
  assign addr_first = {addr[ADDR_W-2:0], mosi};
  assign wbyte      = {shift[6:0], mosi};

  // 00 holds the address, 10 wraps inside a 32-byte page, 01/11 run sequentially.
  always_comb begin
    addr_nxt = addr + ADDR_W'(1);
    if (mode_sel == 2'b00) addr_nxt = addr;
    else if (mode_sel == 2'b10) addr_nxt = {addr[ADDR_W-1:5], addr[4:0] + 5'd1};
  end

  // The first read byte is fetched on the last address edge, before addr itself is updated.
  assign rd_addr  = (state == ADDR) ? addr_first : addr_nxt;
  assign rd_byte  = mem[rd_addr];
  assign bd_rdata = mem[bd_addr];

  assign spi_we = !rst && !cs_n && (state == WDATA) && (bit_cnt == 5'd7);

  // Backdoor access is locked out while a transaction is active, so SPI writes always win.
  always_ff @(posedge clk) begin
    if (spi_we) mem[addr] <= wbyte;
    else if (bd_en && bd_wr && !busy) mem[bd_addr] <= bd_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      addr    <= '0;
      shift   <= 8'd0;
      is_read <= 1'b0;
      miso_q  <= 1'b0;
`ifdef SPI_TARGET_MODE_REG_EN
      mode    <= 8'h40;
`endif
    end else if (cs_n) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      miso_q  <= 1'b0;
    end else begin
      miso_q  <= 1'b0;
      bit_cnt <= bit_cnt + 5'd1;
      case (state)
        IDLE: begin
          state   <= CMD;
          shift   <= {7'd0, mosi};
          bit_cnt <= 5'd1;
        end
        CMD: begin
          shift <= wbyte;
          if (bit_cnt == 5'd7) begin
            bit_cnt <= 5'd0;
            case (wbyte)
              8'h03: begin state <= ADDR; is_read <= 1'b1; end
              8'h02: begin state <= ADDR; is_read <= 1'b0; end
`ifdef SPI_TARGET_MODE_REG_EN
              8'h05: begin state <= RDSR; shift <= mode; miso_q <= mode[7]; end
              8'h01: state <= WRSR;
`endif
              default: state <= IGNORE;
            endcase
          end
        end
        ADDR: begin
          addr <= addr_first;
          if (bit_cnt == 5'd23) begin
            bit_cnt <= 5'd0;
            if (is_read) begin
              state  <= RDATA;
              shift  <= rd_byte;
              miso_q <= rd_byte[7];
            end else begin
              state <= WDATA;
            end
          end
        end
        RDATA: begin
          shift  <= {shift[6:0], shift[7]};
          miso_q <= shift[6];
          if (bit_cnt == 5'd7) begin
            bit_cnt <= 5'd0;
            addr    <= addr_nxt;
            shift   <= rd_byte;
            miso_q  <= rd_byte[7];
          end
        end
        WDATA: begin
          shift <= wbyte;
          if (bit_cnt == 5'd7) begin
            bit_cnt <= 5'd0;
            addr    <= addr_nxt;
          end
        end
`ifdef SPI_TARGET_MODE_REG_EN
        RDSR: begin
          shift  <= {shift[6:0], shift[7]};
          miso_q <= shift[6];
          if (bit_cnt == 5'd7) begin
            bit_cnt <= 5'd0;
            shift   <= mode;
            miso_q  <= mode[7];
          end
        end
        WRSR: begin
          shift <= wbyte;
          if (bit_cnt == 5'd7) begin
            bit_cnt <= 5'd0;
            mode    <= wbyte;
            state   <= IGNORE;
          end
        end
`endif
        default: bit_cnt <= 5'd0;
      endcase
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      assign miso = miso_q;
    end else begin : g_out_comb
      assign miso = ((state == RDATA) || (state == RDSR)) && shift[7];
    end
  endgenerate
endmodule

// File: tb/tb_spi_sram_target.sv
// Bench for spi_sram_target: randomized SPI traffic against a byte-array reference model.
// Mode-register scenarios compile in when SPI_TARGET_MODE_REG_EN is defined.
`timescale 1ns/1ps
module tb_spi_sram_target;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, cs_n, mosi, miso, busy;
  logic              bd_en, bd_wr;
  logic [ADDR_W-1:0] bd_addr;
  logic [7:0]        bd_wdata, bd_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [DEPTH];
  logic [7:0] model_mode = 8'h40;
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];

  spi_sram_target #(.ADDR_W(ADDR_W), .OUT_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso), .busy(busy),
    .bd_en(bd_en), .bd_wr(bd_wr), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // reference addressing rule computed from the mode bits
  function automatic logic [ADDR_W-1:0] next_a(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] page_base;
    page_base = a & ~ADDR_W'(31);
    case (model_mode[7:6])
      2'b00:   return a;
      2'b10:   return page_base | ((a + ADDR_W'(1)) & ADDR_W'(31));
      default: return a + ADDR_W'(1);
    endcase
  endfunction

  // driver tasks
  task automatic spi_bit(input logic b, output logic o);
    @(negedge clk);
    o    = miso;
    cs_n = 1'b0;
    mosi = b;
  endtask

  task automatic spi_byte(input logic [7:0] v, output logic [7:0] o);
    logic bo;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(v[i], bo);
      o[i] = bo;
    end
  endtask

  task automatic spi_header(input logic [7:0] op, input logic [ADDR_W-1:0] a);
    logic [23:0] full;
    logic [7:0]  dummy;
    full = {14'($urandom), a};
    spi_byte(op, dummy);
    spi_byte(full[23:16], dummy);
    spi_byte(full[15:8], dummy);
    spi_byte(full[7:0], dummy);
  endtask

  task automatic spi_end();
    @(negedge clk);
    cs_n  = 1'b1;
    mosi  = 1'b0;
    bd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic spi_read(input logic [ADDR_W-1:0] a, input int n);
    logic [7:0] o;
    logic [ADDR_W-1:0] ea;
    ea = a;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(model_mem[ea]);
      ea = next_a(ea);
    end
    spi_header(8'h03, a);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'($urandom), o);
      rd_q.push_back(o);
    end
    spi_end();
  endtask

  task automatic spi_write(input logic [ADDR_W-1:0] a, input int n);
    logic [7:0] d, o;
    logic [ADDR_W-1:0] ea;
    ea = a;
    spi_header(8'h02, a);
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      spi_byte(d, o);
      model_mem[ea] = d;
      ea = next_a(ea);
    end
    spi_end();
  endtask

  task automatic bd_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_wr = 1'b1; bd_addr = a; bd_wdata = d;
    model_mem[a] = d;
    @(negedge clk);
    bd_en = 1'b0; bd_wr = 1'b0;
  endtask

  task automatic bd_read(input logic [ADDR_W-1:0] a, output logic [7:0] d);
    bd_addr = a;
    #1;
    d = bd_rdata;
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_preload();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      bd_en = 1'b1; bd_wr = 1'b1; bd_addr = ADDR_W'(a); bd_wdata = 8'($urandom);
      model_mem[a] = bd_wdata;
    end
    @(negedge clk);
    bd_en = 1'b0; bd_wr = 1'b0;
  endtask

  task automatic test_read_basic();
    logic [7:0] g;
    bd_write(10'h010, 8'hA1); bd_write(10'h011, 8'hB2);
    bd_write(10'h012, 8'hC3); bd_write(10'h013, 8'hD4);
    spi_read(10'h010, 4);
    exp_q.delete();
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    while (exp_q.size() > 0) begin
      g = rd_q.pop_front();
      total++; if (g !== exp_q[0]) begin bad++; $display("FAIL read_basic got=%h exp=%h", g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    rd_q.delete();
  endtask

  task automatic test_write_wrap();
    logic [7:0] o, g;
    spi_header(8'h02, 10'h3FF);
    spi_byte(8'h5A, o);
    spi_byte(8'h6B, o);
    spi_end();
    model_mem[10'h3FF] = 8'h5A; model_mem[10'h000] = 8'h6B;
    bd_read(10'h3FF, g);
    total++; if (g !== 8'h5A) begin bad++; $display("FAIL wrap_3ff got=%h exp=5a", g); end
    bd_read(10'h000, g);
    total++; if (g !== 8'h6B) begin bad++; $display("FAIL wrap_000 got=%h exp=6b", g); end
  endtask

  task automatic test_abort_write();
    logic o;
    logic [7:0] g;
    spi_header(8'h02, 10'h020);
    repeat (5) spi_bit(1'b1, o);
    spi_end();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    bd_read(10'h020, g);
    total++; if (g !== model_mem[10'h020]) begin bad++; $display("FAIL abort_mem got=%h exp=%h", g, model_mem[10'h020]); end
    spi_read(10'h020, 2);
    while (exp_q.size() > 0) begin
      g = rd_q.pop_front();
      total++; if (g !== exp_q[0]) begin bad++; $display("FAIL abort_read got=%h exp=%h", g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_ignore(input logic [7:0] op);
    logic [7:0] o;
    logic b;
    spi_byte(op, o);
    for (int k = 0; k < 16; k++) begin
      spi_bit(1'($urandom), b);
      total++; if (b !== 1'b0) begin bad++; $display("FAIL ignore_miso op=%h bit=%0d got=%b exp=0", op, k, b); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy op=%h bit=%0d got=%b exp=1", op, k, busy); end
    end
    spi_end();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_idle op=%h got=%b exp=0", op, busy); end
  endtask

  task automatic test_collision();
    logic o;
    logic [7:0] d, g;
    logic [ADDR_W-1:0] a, b;
    a = 10'h155; b = 10'h2AA; d = 8'($urandom);
    spi_header(8'h02, a);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(d[i], o);
      bd_en = (i == 4 || i == 0); bd_wr = 1'b1;
      bd_addr = (i == 0) ? a : b;
      bd_wdata = ~d;
    end
    spi_end();
    model_mem[a] = d;
    bd_read(a, g);
    total++; if (g !== d) begin bad++; $display("FAIL collision_spi got=%h exp=%h", g, d); end
    bd_read(b, g);
    total++; if (g !== model_mem[b]) begin bad++; $display("FAIL collision_busy got=%h exp=%h", g, model_mem[b]); end
  endtask

  task automatic test_random();
    logic [7:0] g;
    logic [ADDR_W-1:0] a;
    int n;
    for (int t = 0; t < 16; t++) begin
      a = (t % 4 == 0) ? ADDR_W'($urandom_range(DEPTH - 3, DEPTH - 1)) : ADDR_W'($urandom);
      n = $urandom_range(1, 5);
      if ($urandom_range(0, 1) == 1) spi_write(a, n);
      else begin
        spi_read(a, n);
        while (exp_q.size() > 0) begin
          g = rd_q.pop_front();
          total++; if (g !== exp_q[0]) begin bad++; $display("FAIL rand_read addr=%h got=%h exp=%h", a, g, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

`ifdef SPI_TARGET_MODE_REG_EN
  task automatic test_mode();
    logic [7:0] o, g;
    spi_byte(8'h01, o);
    spi_byte(8'h80, o);
    spi_end();
    model_mode = 8'h80;
    spi_read(10'h01E, 4);
    while (exp_q.size() > 0) begin
      g = rd_q.pop_front();
      total++; if (g !== exp_q[0]) begin bad++; $display("FAIL page_read got=%h exp=%h", g, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    spi_byte(8'h05, o);
    for (int k = 0; k < 2; k++) begin
      spi_byte(8'h00, g);
      total++; if (g !== model_mode) begin bad++; $display("FAIL rdsr got=%h exp=%h", g, model_mode); end
    end
    spi_end();
  endtask
`endif

  task automatic test_reset_mid_read();
    logic [7:0] o;
    logic b;
    spi_header(8'h03, 10'h100);
    spi_byte(8'h00, o);
    total++; if (o !== model_mem[10'h100]) begin bad++; $display("FAIL pre_reset_read got=%h exp=%h", o, model_mem[10'h100]); end
    repeat (3) spi_bit(1'b0, b);
    @(negedge clk);
    rst = 1'b1;
    model_mode = 8'h40;
    @(negedge clk);
    total++; if (miso !== 1'b0) begin bad++; $display("FAIL midrst_miso got=%b exp=0", miso); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    rst = 1'b0; cs_n = 1'b1;
    @(negedge clk);
`ifdef SPI_TARGET_MODE_REG_EN
    spi_byte(8'h05, o);
    spi_byte(8'h00, o);
    spi_end();
    total++; if (o !== 8'h40) begin bad++; $display("FAIL midrst_mode got=%h exp=40", o); end
`endif
    spi_read(10'h01F, 2);
    while (exp_q.size() > 0) begin
      o = rd_q.pop_front();
      total++; if (o !== exp_q[0]) begin bad++; $display("FAIL post_reset_read got=%h exp=%h", o, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_mem_scan();
    logic [7:0] g;
    for (int a = 0; a < DEPTH; a++) begin
      bd_read(ADDR_W'(a), g);
      total++; if (g !== model_mem[a]) begin bad++; $display("FAIL mem_scan addr=%h got=%h exp=%h", a, g, model_mem[a]); end
    end
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; mosi = 1'b0;
    bd_en = 1'b0; bd_wr = 1'b0; bd_addr = '0; bd_wdata = 8'd0;
    test_reset();
    test_preload();
    test_read_basic();
    test_write_wrap();
    test_abort_write();
    test_ignore(8'h9F);
`ifdef SPI_TARGET_MODE_REG_EN
    test_random();
    test_mode();
`else
    test_ignore(8'h05);
    test_ignore(8'h01);
    test_random();
`endif
    test_collision();
    test_reset_mid_read();
    test_mem_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
